// File: rtl/t2mi_ts_pkg.sv
// rtl/t2mi_ts_pkg.sv - shared constants, state encoding and subsecond limit table for the T2MI timestamp extractor
package t2mi_ts_pkg;

  localparam logic [7:0]  TS_TYPE_DEFAULT = 8'h20;
  localparam logic [15:0] TS_LEN_DEFAULT  = 16'd11;

  localparam int PAYLOAD_W   = 88;
  localparam int RFU_LSB     = 84;
  localparam int BW_LSB      = 80;
  localparam int BW_W        = 4;
  localparam int SEC_LSB     = 40;
  localparam int SEC_FIELD_W = 40;
  localparam int SUB_LSB     = 13;
  localparam int SUB_W       = 27;
  localparam int UTCO_LSB    = 0;
  localparam int UTCO_W      = 13;

  localparam logic [BW_W-1:0] BW_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    SKIP
  } state_t;

  // Subseconds count elementary periods T, so the ceiling depends on bandwidth.
  function automatic logic [SUB_W-1:0] subsec_limit(input logic [BW_W-1:0] bw);
    case (bw)
      4'd0:    subsec_limit = 27'd1845070;
      4'd1:    subsec_limit = 27'd5714285;
      4'd2:    subsec_limit = 27'd6857142;
      4'd3:    subsec_limit = 27'd8000000;
      4'd4:    subsec_limit = 27'd9142857;
      4'd5:    subsec_limit = 27'd11428571;
      default: subsec_limit = 27'd0;
    endcase
  endfunction

endpackage

// File: rtl/t2mi_ts_field_check.sv
// rtl/t2mi_ts_field_check.sv - combinational unpack and range check of the 88-bit timestamp payload
module t2mi_ts_field_check
  import t2mi_ts_pkg::*;
#(
  parameter int SEC_W = 40
) (
  input  logic [PAYLOAD_W-1:0] word,
  output logic [BW_W-1:0]      bw,
  output logic [SEC_W-1:0]     seconds,
  output logic [SUB_W-1:0]     subseconds,
  output logic [UTCO_W-1:0]    utco,
  output logic                 range_ok
);

  logic unused_rfu;

  assign bw         = word[BW_LSB +: BW_W];
  assign seconds    = SEC_W'(word[SEC_LSB +: SEC_FIELD_W]);
  assign subseconds = word[SUB_LSB +: SUB_W];
  assign utco       = word[UTCO_LSB +: UTCO_W];
  assign unused_rfu = ^word[PAYLOAD_W-1:RFU_LSB];

  // Reserved bandwidth codes return a zero limit, so they always fail the range test.
  assign range_ok = (bw <= BW_MAX) && (subseconds < subsec_limit(bw));

endmodule

// File: rtl/t2mi_timestamp_extractor.sv
// rtl/t2mi_timestamp_extractor.sv - captures T2MI timestamp packets and strobes validated fields
// Optional statistics counters are built when T2MI_TS_STATS_EN is defined.
module t2mi_timestamp_extractor
  import t2mi_ts_pkg::*;
#(
  parameter logic [7:0]  TS_TYPE = TS_TYPE_DEFAULT,
  parameter logic [15:0] TS_LEN  = TS_LEN_DEFAULT,
  parameter int          SEC_W   = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              packet_start,
  input  logic [7:0]        packet_type,
  input  logic [15:0]       packet_length,
  input  logic              packet_valid,
  input  logic [7:0]        packet_data,
  input  logic              packet_end,
  input  logic              parser_error,
  output logic              ts_valid,
  output logic [SEC_W-1:0]  ts_seconds,
  output logic [SUB_W-1:0]  ts_subseconds,
  output logic [UTCO_W-1:0] ts_utco,
  output logic [BW_W-1:0]   ts_bw,
  output logic              ts_len_error,
  output logic              ts_range_error
`ifdef T2MI_TS_STATS_EN
  ,
  output logic [15:0]       stat_good,
  output logic [15:0]       stat_len_err,
  output logic [15:0]       stat_range_err
`endif
);

  state_t               state;
  logic [15:0]          count;
  logic                 overrun;
  logic [PAYLOAD_W-1:0] sreg;

  logic [BW_W-1:0]   fc_bw;
  logic [SEC_W-1:0]  fc_seconds;
  logic [SUB_W-1:0]  fc_subseconds;
  logic [UTCO_W-1:0] fc_utco;
  logic              fc_range_ok;

  logic   start_is_ts;
  logic   start_len_ok;
  state_t start_next;

  assign start_is_ts  = (packet_type == TS_TYPE);
  assign start_len_ok = (packet_length == TS_LEN);
  assign start_next   = (start_is_ts && start_len_ok) ? COLLECT : SKIP;

  t2mi_ts_field_check #(.SEC_W(SEC_W)) u_field_check (
    .word       (sreg),
    .bw         (fc_bw),
    .seconds    (fc_seconds),
    .subseconds (fc_subseconds),
    .utco       (fc_utco),
    .range_ok   (fc_range_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      overrun        <= 1'b0;
      sreg           <= '0;
      ts_valid       <= 1'b0;
      ts_len_error   <= 1'b0;
      ts_range_error <= 1'b0;
      ts_seconds     <= '0;
      ts_subseconds  <= '0;
      ts_utco        <= '0;
      ts_bw          <= '0;
    end else begin
      ts_valid       <= 1'b0;
      ts_len_error   <= 1'b0;
      ts_range_error <= 1'b0;
      if (parser_error) begin
        ts_len_error <= (state == COLLECT);
        state        <= IDLE;
        count        <= '0;
        overrun      <= 1'b0;
      end else begin
        case (state)
          IDLE, SKIP: begin
            if (packet_start) begin
              state        <= start_next;
              count        <= '0;
              overrun      <= 1'b0;
              ts_len_error <= start_is_ts && !start_len_ok;
            end else if (state == SKIP && packet_end) begin
              state <= IDLE;
            end
          end
          COLLECT: begin
            // A new start aborts the capture; its own length error folds into the same pulse.
            if (packet_start) begin
              ts_len_error <= 1'b1;
              state        <= start_next;
              count        <= '0;
              overrun      <= 1'b0;
            end else begin
              if (packet_valid) begin
                if (count == TS_LEN) begin
                  overrun <= 1'b1;
                end else begin
                  sreg  <= {sreg[PAYLOAD_W-9:0], packet_data};
                  count <= count + 16'd1;
                end
              end
              if (packet_end) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (count != TS_LEN || overrun) begin
              ts_len_error <= 1'b1;
            end else if (!fc_range_ok) begin
              ts_range_error <= 1'b1;
            end else begin
              ts_valid      <= 1'b1;
              ts_seconds    <= fc_seconds;
              ts_subseconds <= fc_subseconds;
              ts_utco       <= fc_utco;
              ts_bw         <= fc_bw;
            end
            // A start landing on the check cycle is still tracked; its length error is dropped
            // because this cycle already owns the single result pulse.
            state   <= packet_start ? start_next : IDLE;
            count   <= '0;
            overrun <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef T2MI_TS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good      <= '0;
      stat_len_err   <= '0;
      stat_range_err <= '0;
    end else begin
      if (ts_valid && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      if (ts_len_error && stat_len_err != 16'hFFFF) stat_len_err <= stat_len_err + 16'd1;
      if (ts_range_error && stat_range_err != 16'hFFFF) stat_range_err <= stat_range_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t2mi_timestamp_extractor.sv
// tb/tb_t2mi_timestamp_extractor.sv - directed self-checking bench with a packet-level outcome model
module tb_t2mi_timestamp_extractor;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        packet_start = 1'b0;
  logic [7:0]  packet_type = '0;
  logic [15:0] packet_length = '0;
  logic        packet_valid = 1'b0;
  logic [7:0]  packet_data = '0;
  logic        packet_end = 1'b0;
  logic        parser_error = 1'b0;
  logic        ts_valid;
  logic [39:0] ts_seconds;
  logic [26:0] ts_subseconds;
  logic [12:0] ts_utco;
  logic [3:0]  ts_bw;
  logic        ts_len_error;
  logic        ts_range_error;
`ifdef T2MI_TS_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_len_err;
  logic [15:0] stat_range_err;
`endif

  t2mi_timestamp_extractor dut (
    .clk            (clk),
    .rst            (rst),
    .packet_start   (packet_start),
    .packet_type    (packet_type),
    .packet_length  (packet_length),
    .packet_valid   (packet_valid),
    .packet_data    (packet_data),
    .packet_end     (packet_end),
    .parser_error   (parser_error),
    .ts_valid       (ts_valid),
    .ts_seconds     (ts_seconds),
    .ts_subseconds  (ts_subseconds),
    .ts_utco        (ts_utco),
    .ts_bw          (ts_bw),
    .ts_len_error   (ts_len_error),
    .ts_range_error (ts_range_error)
`ifdef T2MI_TS_STATS_EN
    ,
    .stat_good      (stat_good),
    .stat_len_err   (stat_len_err),
    .stat_range_err (stat_range_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  // Expected outcome per cycle: 0 none, 1 ts_valid, 2 ts_len_error, 3 ts_range_error.
  int          exp_ev  [MAXC];
  bit          exp_clr [MAXC];
  logic [39:0] exp_sec [MAXC];
  logic [26:0] exp_sub [MAXC];
  logic [12:0] exp_utco[MAXC];
  logic [3:0]  exp_bw  [MAXC];

  logic [39:0] h_sec = '0;
  logic [26:0] h_sub = '0;
  logic [12:0] h_utco = '0;
  logic [3:0]  h_bw = '0;
  int m_good = 0, m_len = 0, m_rng = 0;

  int lim [0:5] = '{1845070, 5714285, 6857142, 8000000, 9142857, 11428571};
  logic [7:0] pb [0:15];
  bit m_coll = 0;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (exp_clr[cyc]) begin
        h_sec = '0; h_sub = '0; h_utco = '0; h_bw = '0;
        m_good = 0; m_len = 0; m_rng = 0;
      end
      if (exp_ev[cyc] == 1) begin
        h_sec = exp_sec[cyc]; h_sub = exp_sub[cyc]; h_utco = exp_utco[cyc]; h_bw = exp_bw[cyc];
        m_good++;
      end
      if (exp_ev[cyc] == 2) m_len++;
      if (exp_ev[cyc] == 3) m_rng++;
      n_vec++;
      if ({ts_valid, ts_len_error, ts_range_error} !==
          {exp_ev[cyc] == 1, exp_ev[cyc] == 2, exp_ev[cyc] == 3}) begin
        n_fail++;
        $display("FAIL pulses cycle %0d: got valid/len/range=%b%b%b required %b%b%b", cyc,
                 ts_valid, ts_len_error, ts_range_error,
                 exp_ev[cyc] == 1, exp_ev[cyc] == 2, exp_ev[cyc] == 3);
      end
      n_vec++;
      if ({ts_bw, ts_seconds, ts_subseconds, ts_utco} !== {h_bw, h_sec, h_sub, h_utco}) begin
        n_fail++;
        $display("FAIL fields cycle %0d: got bw=%0d sec=%h sub=%0d utco=%0d required bw=%0d sec=%h sub=%0d utco=%0d",
                 cyc, ts_bw, ts_seconds, ts_subseconds, ts_utco, h_bw, h_sec, h_sub, h_utco);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int c, input int ev);
    if (c < MAXC) exp_ev[c] = ev;
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  task automatic set_payload(input logic [3:0] bw, input logic [39:0] sec,
                             input logic [26:0] sub, input logic [12:0] utco);
    logic [87:0] v;
    v = {4'h0, bw, sec, sub, utco};
    for (int i = 0; i < 11; i++) pb[i] = v[87-8*i -: 8];
  endtask

  task automatic model_start(input logic [7:0] typ, input logic [15:0] len, input int c);
    if (m_coll) mark(c + 1, 2);
    m_coll = 0;
    if (typ == 8'h20) begin
      if (len == 16'd11) m_coll = 1;
      else mark(c + 1, 2);
    end
  endtask

  task automatic model_end(input int c_end, input int nb);
    logic [87:0] v;
    logic [3:0]  bw;
    logic [26:0] sub;
    int c;
    if (!m_coll) return;
    m_coll = 0;
    c = c_end + 2;
    if (nb != 11) begin
      mark(c, 2);
      return;
    end
    v = '0;
    for (int i = 0; i < 11; i++) v = (v << 8) | 88'(pb[i]);
    bw  = v[83:80];
    sub = v[39:13];
    if (bw > 4'd5) mark(c, 3);
    else if (int'(sub) >= lim[int'(bw)]) mark(c, 3);
    else begin
      mark(c, 1);
      exp_bw[c] = bw; exp_sec[c] = v[79:40]; exp_sub[c] = sub; exp_utco[c] = v[12:0];
    end
  endtask

  task automatic send_pkt(input logic [7:0] typ, input logic [15:0] len, input int nb, input bit end_same);
    int c_end;
    packet_start = 1; packet_type = typ; packet_length = len;
    model_start(typ, len, cyc);
    tick;
    packet_start = 0;
    c_end = 0;
    for (int i = 0; i < nb; i++) begin
      packet_valid = 1; packet_data = pb[i];
      if (end_same && i == nb - 1) begin
        packet_end = 1; c_end = cyc;
      end
      tick;
    end
    packet_valid = 0;
    if (!end_same || nb == 0) begin
      packet_end = 1; c_end = cyc;
      tick;
    end
    packet_end = 0;
    model_end(c_end, nb);
    repeat (4) tick;
  endtask

  task automatic send_partial(input int nb);
    packet_start = 1; packet_type = 8'h20; packet_length = 16'd11;
    model_start(8'h20, 16'd11, cyc);
    tick;
    packet_start = 0;
    for (int i = 0; i < nb; i++) begin
      packet_valid = 1; packet_data = 8'hA0 + 8'(i);
      tick;
    end
    packet_valid = 0;
  endtask

  task automatic trailing_bytes(input int nb);
    for (int i = 0; i < nb; i++) begin
      packet_valid = 1; packet_data = 8'h5A;
      packet_end = (i == nb - 1);
      tick;
    end
    packet_valid = 0; packet_end = 0;
    repeat (3) tick;
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_ev[i] = 0; exp_clr[i] = 0;
    end
    repeat (3) tick;
    rst = 0;
    repeat (2) tick;
    lit("reset_bw", 64'(ts_bw), 64'd0);
    lit("reset_seconds", 64'(ts_seconds), 64'd0);

    pb[0] = 8'h03; pb[1] = 8'h00; pb[2] = 8'h12; pb[3] = 8'h34; pb[4] = 8'h56; pb[5] = 8'h78;
    pb[6] = 8'h00; pb[7] = 8'h00; pb[8] = 8'h7D; pb[9] = 8'h00; pb[10] = 8'h25;
    send_pkt(8'h20, 16'd11, 11, 1);
    lit("first_bw", 64'(ts_bw), 64'd3);
    lit("first_seconds", 64'(ts_seconds), 64'h0012345678);
    lit("first_subseconds", 64'(ts_subseconds), 64'd1000);
    lit("first_utco", 64'(ts_utco), 64'd37);

    for (int i = 0; i < 10; i++) pb[i] = 8'hC0 + 8'(i);
    send_pkt(8'h10, 16'd10, 10, 0);
    lit("held_seconds", 64'(ts_seconds), 64'h0012345678);

    set_payload(4'd3, 40'h1, 27'd1000, 13'd1);
    send_pkt(8'h20, 16'd11, 8, 1);

    set_payload(4'd3, 40'h7, 27'd8000000, 13'd2);
    send_pkt(8'h20, 16'd11, 11, 1);
    set_payload(4'd6, 40'h8, 27'd0, 13'd3);
    send_pkt(8'h20, 16'd11, 11, 0);
    set_payload(4'd5, 40'hABCDEF0123, 27'd11428570, 13'd18);
    send_pkt(8'h20, 16'd11, 11, 0);
    lit("bw5_bw", 64'(ts_bw), 64'd5);
    lit("bw5_subseconds", 64'(ts_subseconds), 64'd11428570);

    send_pkt(8'h20, 16'd12, 12, 1);

    set_payload(4'd1, 40'h42, 27'd5, 13'd9);
    pb[11] = 8'hEE;
    send_pkt(8'h20, 16'd11, 12, 1);

    set_payload(4'd2, 40'h55, 27'd6857141, 13'd100);
    send_partial(4);
    send_pkt(8'h20, 16'd11, 11, 0);
    lit("restart_bw", 64'(ts_bw), 64'd2);
    lit("restart_seconds", 64'(ts_seconds), 64'h55);

    send_partial(4);
    parser_error = 1; packet_valid = 1; packet_data = 8'h77;
    if (m_coll) mark(cyc + 1, 2);
    m_coll = 0;
    tick;
    parser_error = 0;
    trailing_bytes(3);
    set_payload(4'd4, 40'd99, 27'd9142856, 13'd7);
    send_pkt(8'h20, 16'd11, 11, 1);

    send_partial(3);
    rst = 1;
    if (cyc + 1 < MAXC) exp_clr[cyc + 1] = 1;
    m_coll = 0;
    tick;
    rst = 0;
    trailing_bytes(8);
    lit("post_reset_seconds", 64'(ts_seconds), 64'd0);
    set_payload(4'd0, 40'd12, 27'd1845069, 13'd4);
    send_pkt(8'h20, 16'd11, 11, 0);
    set_payload(4'd0, 40'd13, 27'd1845070, 13'd4);
    send_pkt(8'h20, 16'd11, 11, 1);

    repeat (5) tick;
`ifdef T2MI_TS_STATS_EN
    lit("stat_good", 64'(stat_good), 64'(m_good));
    lit("stat_len_err", 64'(stat_len_err), 64'(m_len));
    lit("stat_range_err", 64'(stat_range_err), 64'(m_rng));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/t2mi_timestamp_extractor.md
Name: t2mi_timestamp_extractor

Overview:
- Sits directly downstream of the T2MI packet parser, on its byte stream: packet_start/type/length, packet_valid/data, packet_end, parser_error.
- Selects T2MI timestamp packets (type 0x20) and collects their 11-byte payload.
- Unpacks and range-checks the payload, then presents seconds/subseconds/UTC offset to the PPS generator as a single-cycle validated strobe.

Parameters:
- TS_TYPE, 8'h20, packet type captured as a timestamp.
- TS_LEN, 16'd11, required payload length in bytes.
- SEC_W, 40, seconds-since-2000 field width.

Ports:
- clk  in  1  system clock (100 MHz domain, same as parser output).
- rst  in  1  synchronous reset, active-high.
- packet_start  in  1  one-cycle pulse; packet_type/packet_length valid this cycle.
- packet_type  in  8  packet type.
- packet_length  in  16  payload length in bytes.
- packet_valid  in  1  packet_data holds a payload byte this cycle.
- packet_data  in  8  payload byte, MSB-first order.
- packet_end  in  1  last-byte marker; may coincide with the last packet_valid or follow it.
- parser_error  in  1  upstream error; aborts the current capture.
- ts_valid  out  1  one-cycle pulse: new timestamp fields valid.
- ts_seconds  out  SEC_W  seconds since 2000-01-01.
- ts_subseconds  out  27  subseconds in elementary periods T.
- ts_utco  out  13  UTC offset.
- ts_bw  out  4  bandwidth code.
- ts_len_error  out  1  one-cycle pulse: wrong declared or actual length, or truncated capture.
- ts_range_error  out  1  one-cycle pulse: bw > 5, or subseconds >= limit for bw.

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; shift register 0.
- Payload bit layout, 88 bits MSB-first:
  - rfu[87:84]
  - bw[83:80]
  - seconds[79:40]
  - subseconds[39:13]
  - utco[12:0]
- IDLE, on packet_start:
  - packet_type==TS_TYPE and packet_length==TS_LEN -> COLLECT, counter cleared.
  - packet_type==TS_TYPE and any other length -> ts_len_error next cycle; go to SKIP.
  - Any other type -> SKIP.
- COLLECT:
  - Each packet_valid shifts the byte into the 88-bit register and increments the counter (saturates at TS_LEN).
  - Bytes beyond TS_LEN are ignored and set an overrun flag.
  - packet_end (with or without packet_valid in the same cycle; that byte is counted first) -> CHECK.
- CHECK (one cycle), evaluated in priority order:
  - count != TS_LEN or overrun -> ts_len_error.
  - Else bw > 5 or subseconds >= SUBSEC_LIMIT[bw] -> ts_range_error.
  - Else load ts_* fields and pulse ts_valid.
  - Then IDLE.
- Latency: ts_valid (or an error pulse) is asserted exactly 2 cycles after the cycle packet_end is sampled.
- SKIP: wait for packet_end, then IDLE. No outputs.
- packet_start in COLLECT: current capture aborts, ts_len_error pulses, and the new start is evaluated as in IDLE in the same cycle.
- packet_start in SKIP: treated as from IDLE.
- parser_error high in any state:
  - Capture discarded, state -> IDLE.
  - ts_len_error pulses only if the state was COLLECT.
  - parser_error has priority over a simultaneous packet_start or packet_end.
- ts_* fields hold their values until the next successful ts_valid; error pulses never modify them.
- Only one of ts_valid/ts_len_error/ts_range_error is high in any cycle.
- Reset mid-packet: state returns to IDLE; the rest of that packet is ignored until the next packet_start.

Optional Feature:
- T2MI_TS_STATS_EN defined: adds outputs stat_good[15:0], stat_len_err[15:0], stat_range_err[15:0].
  - Each increments on its pulse and saturates at 16'hFFFF.
  - Cleared by rst only.
- Undefined: these ports and counters are absent.

Decomposition:
- Package t2mi_ts_pkg holds:
  - TS_TYPE_DEFAULT, TS_LEN_DEFAULT.
  - Bit-field offset constants.
  - State encoding: IDLE, COLLECT, CHECK, SKIP.
  - SUBSEC_LIMIT table indexed by bw: 0: 1845070, 1: 5714285, 2: 6857142, 3: 8000000, 4: 9142857, 5: 11428571.
- One sub-module is natural: t2mi_ts_field_check, combinational unpack plus range check on the 88-bit word.

Test Plan:
- Type 0x20, len 11, bytes 0x03,0x00,0x12,0x34,0x56,0x78, then subsec=1000, utco=37 packed -> ts_valid 2 cycles after packet_end; ts_bw=3, ts_seconds=40'h0012345678, ts_subseconds=1000, ts_utco=37.
- Type 0x10, len 10 -> no output pulses; held ts_* values unchanged.
- Type 0x20, len 11, only 8 bytes before packet_end -> ts_len_error once; ts_valid stays 0.
- bw=3, subseconds=8000000 -> ts_range_error. bw=6 -> ts_range_error. bw=5, subseconds=11428570 -> ts_valid.
- packet_start mid-COLLECT, followed by a valid timestamp packet -> one ts_len_error, then ts_valid with the second packet's fields.
- parser_error at byte 5, then a valid packet -> ts_len_error, then correct ts_valid. With T2MI_TS_STATS_EN defined: stat_good=1, stat_len_err=1.
